rb_cfg_bank: RTL and testbench
==============================

Name: rb_cfg_bank

Overview:
Parametrised, bus-accessed register bank. It replaces the fixed per-block configuration structs with one generic block that provides the following:
- NUM_CFG read/write configuration words.
- NUM_STS sticky write-one-to-clear status words, with a maskable interrupt.
- Optional shadow/commit so that configuration updates reach the DSP and sampler atomically.

It sits between the host command decoder (UART/SPI bridge) and the datapath blocks, which consume the flattened cfg_q bus.

Parameters:
DATA_W, 8, register width in bits (1..32)
NUM_CFG, 4, number of configuration registers (1..64)
NUM_STS, 2, number of sticky status registers (1..64)
ADDR_W, 8, request address width; must satisfy 2^ADDR_W >= NUM_CFG+NUM_STS+2
CFG_RST, 0, reset value loaded into every configuration register (DATA_W bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  bus request valid
req_ready  out  1  bus request accept
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  register address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid (one per accepted request, reads and writes)
rsp_ready  in  1  response accept
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  address out of range
commit_strobe  in  1  external atomic-update pulse (e.g. frame/sample sync)
cfg_q  out  NUM_CFG*DATA_W  active configuration; register i occupies bits [i*DATA_W +: DATA_W]
sts_in  in  NUM_STS*DATA_W  status event bits, level or pulse, same packing as cfg_q
sts_irq  out  1  OR of (sticky status AND irq mask), registered

Behaviour:
- Clock and reset: single clock domain clk. rst_n is asynchronous active-low.
- Address map (A = NUM_CFG, B = NUM_CFG+NUM_STS):
  - 0..A-1: config, read/write.
  - A..B-1: status; a read returns the sticky value; a write clears the bits written as 1.
  - B: IRQ_MASK, read/write; bit j enables bit j of every status word.
  - B+1: COMMIT; a write of any data triggers a commit; a read returns {0.., pending}.
  - Any address above B+1 is an error: rsp_err=1, rsp_rdata=0, no state change.
- Reset values: cfg_q=CFG_RST replicated; shadow=CFG_RST; sticky status=0; mask=0; pending=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; sts_irq=0. req_ready=1 after reset.
- Handshake:
  - A request is accepted when req_valid && req_ready. Comb: req_ready = !rsp_valid || rsp_ready.
  - The response is registered; rsp_valid rises on the cycle after acceptance and holds, with data stable, until rsp_ready.
  - Back-to-back throughput is 1 request/cycle when rsp_ready=1.
  - A read returns the register value as it was before any same-cycle update.
- Write side effects occur on the acceptance edge.
- Sticky status, per bit, every cycle: sts_q <= (sts_q & ~clr) | sts_in. Set wins over a simultaneous W1C clear.
- sts_irq is registered: 1-cycle latency from the sts_q change. Mask changes also take effect with 1-cycle latency.
- Reset mid-transaction: any outstanding response is dropped; no partial write is retained.
- cfg_q is driven only from flops, never combinationally from the bus.

Optional Feature:
RB_SHADOW_EN
- Defined:
  - Config writes go to shadow registers, and pending is set.
  - Config reads return the shadow value.
  - A commit event (COMMIT write or commit_strobe) copies all shadows to cfg_q on that edge and clears pending. cfg_q changes 1 cycle after the commit event.
  - A config write in the same cycle as a commit: the commit copies the old shadow; the new value lands in shadow; pending stays 1.
  - A COMMIT write and commit_strobe together form a single commit.
- Not defined:
  - No shadow flops exist; config writes update cfg_q directly, 1 cycle after acceptance.
  - A COMMIT write is accepted as a no-op (rsp_err=0); its read returns 0.
  - commit_strobe is ignored.

Test Plan (DATA_W=8, NUM_CFG=4, NUM_STS=2, ADDR_W=4, CFG_RST=8'h00: cfg 0-3, status 4-5, mask 6, commit 7):
- Reset: assert rst_n=0 mid-response, then release → cfg_q=32'h0, rsp_valid=0, sts_irq=0, req_ready=1; no response emitted for the aborted request.
- Write 8'hA5 to addr 2, then read addr 2 with rsp_ready=1 every cycle → cfg_q[23:16]=A5 (shadow off), or unchanged (shadow on); readback is A5 in both cases, with 1-cycle response latency.
- Pulse sts_in[1] bit 3 once; write 8'h08 to mask (addr 6) → sts_irq=1 two cycles after the mask write. Write 8'h08 to addr 5 → sts_irq=0. Repeat with sts_in held high during the clear → bit stays set.
- Read addr 9 → rsp_err=1, rsp_rdata=0, no register changed. Hold rsp_ready=0 for 3 cycles → rsp_valid held, req_ready=0, a second request stalls.
- RB_SHADOW_EN: write 8'h11 to addr 0 and 8'h22 to addr 1 → cfg_q unchanged, and COMMIT read = 1. Pulse commit_strobe → cfg_q[15:0]=16'h2211 on the next cycle, and COMMIT read = 0. Then write addr 0 and pulse commit_strobe in the same cycle → old shadow applied, pending = 1.
- Back-to-back: 4 consecutive writes to addrs 0-3 with rsp_ready=1 → 4 responses on consecutive cycles, and req_ready stays high throughout.

Source files
------------

// File: rtl/rb_cfg_bank.sv
// rb_cfg_bank: generic bus-accessed register bank.
//   - NUM_CFG read/write configuration words, exported flat on cfg_q
//   - NUM_STS sticky status words (write-one-to-clear) with a masked,
//     registered interrupt
//   - optional shadow/commit stage, enabled by defining RB_SHADOW_EN
//
// Address map (A = NUM_CFG, B = NUM_CFG+NUM_STS):
//   0..A-1  config        A..B-1  status (W1C)
//   B       IRQ_MASK      B+1     COMMIT (write = commit, read = pending)
//   >B+1    error (rsp_err=1, rdata 0, no side effects)
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/ready       request handshake; req_write, req_addr, req_wdata
//   rsp_valid/ready       registered response; rsp_rdata, rsp_err
//   commit_strobe         external commit pulse (shadow build only)
//   cfg_q                 active configuration, word i at [i*DATA_W +: DATA_W]
//   sts_in                status event bits, same packing as cfg_q
//   sts_irq               registered OR of (sticky & mask)
module rb_cfg_bank #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       NUM_CFG = 4,
    parameter int unsigned       NUM_STS = 2,
    parameter int unsigned       ADDR_W  = 8,
    parameter logic [DATA_W-1:0] CFG_RST = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    input  logic                        commit_strobe,
    output logic [NUM_CFG*DATA_W-1:0]   cfg_q,
    input  logic [NUM_STS*DATA_W-1:0]   sts_in,
    output logic                        sts_irq
);

    localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(NUM_CFG + NUM_STS);
    localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(NUM_CFG + NUM_STS + 1);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    rsp_t                             rsp_r;
    logic [NUM_CFG-1:0][DATA_W-1:0]   cfg_r;     // active words
    logic [NUM_CFG-1:0][DATA_W-1:0]   cfg_view;  // what a config read returns
    logic [NUM_STS-1:0][DATA_W-1:0]   sts_ev;
    logic [NUM_STS-1:0][DATA_W-1:0]   sts_r;
    logic [NUM_CFG-1:0]               cfg_we;
    logic [DATA_W-1:0]                mask_r;
    logic [DATA_W-1:0]                sts_or;
    logic [DATA_W-1:0]                rd_data;
    logic [DATA_W-1:0]                commit_rd;
    logic                             rd_err;
    logic                             accept;
    logic                             wr_accept;
    logic                             irq_r;

    assign req_ready = !rsp_r.valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wr_accept = accept && req_write;

    assign rsp_valid = rsp_r.valid;
    assign rsp_err   = rsp_r.err;
    assign rsp_rdata = rsp_r.rdata;
    assign cfg_q     = cfg_r;
    assign sts_ev    = sts_in;
    assign sts_irq   = irq_r;

`ifdef RB_SHADOW_EN
    logic commit;
    logic pending;

    // A COMMIT write and a strobe in the same cycle collapse into one commit.
    assign commit    = commit_strobe || (wr_accept && req_addr == COMMIT_ADDR);
    assign commit_rd = DATA_W'(pending);

    // A config write wins over a same-cycle commit: the new value is still
    // sitting in the shadow afterwards, so pending must stay set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pending <= 1'b0;
        else if (|cfg_we)   pending <= 1'b1;
        else if (commit)    pending <= 1'b0;
    end
`else
    logic unused_commit;
    assign unused_commit = commit_strobe;
    assign commit_rd     = '0;
`endif

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
        logic [DATA_W-1:0] act;

        assign cfg_we[i] = wr_accept && (req_addr == ADDR_W'(i));
        assign cfg_r[i]  = act;
`ifdef RB_SHADOW_EN
        logic [DATA_W-1:0] shadow;

        // Commit copies the pre-edge shadow, so a same-cycle write is
        // deferred to the next commit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow <= CFG_RST;
                act    <= CFG_RST;
            end else begin
                if (cfg_we[i]) shadow <= req_wdata;
                if (commit)    act    <= shadow;
            end
        end
        assign cfg_view[i] = shadow;
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         act <= CFG_RST;
            else if (cfg_we[i]) act <= req_wdata;
        end
        assign cfg_view[i] = act;
`endif
    end

    for (genvar k = 0; k < NUM_STS; k++) begin : g_sts
        logic [DATA_W-1:0] sticky;
        logic [DATA_W-1:0] clr;

        assign clr      = (wr_accept && req_addr == ADDR_W'(NUM_CFG + k)) ? req_wdata : '0;
        assign sts_r[k] = sticky;

        // New events are OR'd in after the clear, so a set beats a W1C.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sticky <= '0;
            else        sticky <= (sticky & ~clr) | sts_ev[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 mask_r <= '0;
        else if (wr_accept && req_addr == MASK_ADDR) mask_r <= req_wdata;
    end

    always_comb begin
        sts_or = '0;
        for (int k = 0; k < NUM_STS; k++) sts_or = sts_or | sts_r[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_r <= 1'b0;
        else        irq_r <= |(sts_or & mask_r);
    end

    // Read mux works on pre-edge state, so a read sees the value before any
    // same-cycle write or status update.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CFG; i++)
            if (req_addr == ADDR_W'(i)) rd_data = cfg_view[i];
        for (int k = 0; k < NUM_STS; k++)
            if (req_addr == ADDR_W'(NUM_CFG + k)) rd_data = sts_r[k];
        if (req_addr == MASK_ADDR)   rd_data = mask_r;
        if (req_addr == COMMIT_ADDR) rd_data = commit_rd;
        rd_err = (req_addr > COMMIT_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_r <= '0;
        end else if (accept) begin
            rsp_r.valid <= 1'b1;
            rsp_r.err   <= rd_err;
            rsp_r.rdata <= (req_write || rd_err) ? '0 : rd_data;
        end else if (rsp_ready) begin
            rsp_r.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rb_cfg_bank.sv
// Randomized + directed bench for rb_cfg_bank (DATA_W=8, NUM_CFG=4,
// NUM_STS=2, ADDR_W=4). A per-cycle array model derived from the register
// map rules predicts every output; works with or without RB_SHADOW_EN.
module tb_rb_cfg_bank;

`ifdef RB_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        commit_strobe;
    logic [31:0] cfg_q;
    logic [15:0] sts_in;
    logic        sts_irq;

    always #5 clk = ~clk;

    rb_cfg_bank #(
        .DATA_W(8), .NUM_CFG(4), .NUM_STS(2), .ADDR_W(4), .CFG_RST(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .commit_strobe(commit_strobe),
        .cfg_q(cfg_q), .sts_in(sts_in), .sts_irq(sts_irq)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [7:0] m_cfg[4], m_sh[4], m_sts[2];
    logic [7:0] m_mask, m_rd;
    logic       m_pend, m_irq, m_rv, m_err;

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin m_cfg[i] = 8'h00; m_sh[i] = 8'h00; end
        m_sts[0] = 8'h00; m_sts[1] = 8'h00;
        m_mask = 8'h00; m_rd = 8'h00;
        m_pend = 1'b0; m_irq = 1'b0; m_rv = 1'b0; m_err = 1'b0;
    endtask

    task automatic drive(input bit v, input bit w, input int a, input int d);
        req_valid = v; req_write = w; req_addr = 4'(a); req_wdata = 8'(d);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0);
    endtask

    // One clock: check outputs at negedge against the model, predict the
    // next state from the current inputs, apply it just after the posedge.
    task automatic step();
        logic       acc, wr, er, cmt, npend, nirq, nrv, nerr;
        int         a;
        logic [7:0] rv, clr, nmask, nrd;
        logic [7:0] ncfg[4], nsh[4], nsts[2];
        @(negedge clk);
        chk("cfg_q", cfg_q, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
        chk("sts_irq", sts_irq, m_irq);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("req_ready", req_ready, !m_rv || rsp_ready);
        if (m_rv) begin
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_err", rsp_err, m_err);
        end
        a   = int'(req_addr);
        acc = req_valid && (!m_rv || rsp_ready);
        wr  = acc && req_write;
        rv = 8'h00; er = 1'b0;
        if (a < 4)       rv = SH ? m_sh[a] : m_cfg[a];
        else if (a < 6)  rv = m_sts[a-4];
        else if (a == 6) rv = m_mask;
        else if (a == 7) rv = SH ? {7'd0, m_pend} : 8'h00;
        else             er = 1'b1;
        ncfg = m_cfg; nsh = m_sh; nmask = m_mask; npend = m_pend;
        nrd = m_rd; nerr = m_err;
        nirq = ((m_sts[0] | m_sts[1]) & m_mask) != 8'h00;
        nrv  = acc ? 1'b1 : (rsp_ready ? 1'b0 : m_rv);
        if (acc) begin
            nrd  = (req_write || er) ? 8'h00 : rv;
            nerr = er;
        end
        for (int k = 0; k < 2; k++) begin
            clr = (wr && a == 4 + k) ? req_wdata : 8'h00;
            nsts[k] = (m_sts[k] & ~clr) | sts_in[k*8 +: 8];
        end
        if (wr && a == 6) nmask = req_wdata;
        cmt = SH && (commit_strobe || (wr && a == 7));
        if (cmt) ncfg = m_sh;
        if (wr && a < 4) begin
            if (SH) begin nsh[a] = req_wdata; npend = 1'b1; end
            else    ncfg[a] = req_wdata;
        end else if (cmt) begin
            npend = 1'b0;
        end
        @(posedge clk);
        #1;
        m_cfg = ncfg; m_sh = nsh; m_sts = nsts; m_mask = nmask;
        m_pend = npend; m_irq = nirq; m_rv = nrv; m_rd = nrd; m_err = nerr;
    endtask

    initial begin
        idle();
        rsp_ready = 1'b1; commit_strobe = 1'b0; sts_in = 16'h0000;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset while a response is outstanding
        drive(1, 1, 1, 'hA5); step();
        rsp_ready = 1'b0;
        drive(1, 0, 1, 0); step();
        idle(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_cfg_q", cfg_q, 32'h0);
        chk("rst_irq", sts_irq, 0);
        chk("rst_rdata", rsp_rdata, 0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        chk("post_rst_no_rsp", rsp_valid, 0);

        // write then read back addr 2
        drive(1, 1, 2, 'hA5); step();
        chk("a5_cfg", cfg_q[23:16], SH ? 8'h00 : 8'hA5);
        drive(1, 0, 2, 0); step();
        chk("a5_rd", rsp_rdata, 8'hA5);
        idle(); step();

        // sticky status and masked irq
        sts_in = 16'h0800; step(); sts_in = 16'h0000;
        drive(1, 1, 6, 'h08); step();
        chk("irq_lat", sts_irq, 0);
        idle(); step();
        chk("irq_set", sts_irq, 1);
        drive(1, 1, 5, 'h08); step();
        idle(); step();
        chk("irq_clr", sts_irq, 0);
        sts_in = 16'h0800; step();
        drive(1, 1, 5, 'h08); step();
        sts_in = 16'h0000; idle(); step();
        chk("irq_held", sts_irq, 1);
        drive(1, 0, 5, 0); step();
        chk("sts_held_rd", rsp_rdata, 8'h08);
        drive(1, 1, 5, 'hFF); step();
        idle(); step(); step();

        // out-of-range address and response stall
        drive(1, 0, 9, 0); step();
        chk("err_flag", rsp_err, 1);
        chk("err_rdata", rsp_rdata, 0);
        idle(); step();
        rsp_ready = 1'b0;
        drive(1, 0, 2, 0); step();
        drive(1, 0, 3, 0);
        repeat (3) step();
        chk("stall_valid", rsp_valid, 1);
        chk("stall_ready", req_ready, 0);
        chk("stall_data", rsp_rdata, 8'hA5);
        rsp_ready = 1'b1; step();
        chk("stall_next", rsp_rdata, 8'h00);
        idle(); step();

`ifdef RB_SHADOW_EN
        drive(1, 1, 0, 'h11); step();
        drive(1, 1, 1, 'h22); step();
        drive(1, 0, 7, 0); step();
        chk("sh_pend1", rsp_rdata, 1);
        chk("sh_unch", cfg_q[15:0], 16'h0000);
        idle(); commit_strobe = 1'b1; step(); commit_strobe = 1'b0;
        chk("sh_commit", cfg_q[15:0], 16'h2211);
        drive(1, 0, 7, 0); step();
        chk("sh_pend0", rsp_rdata, 0);
        drive(1, 1, 0, 'h33); commit_strobe = 1'b1; step(); commit_strobe = 1'b0;
        chk("sh_old", cfg_q[7:0], 8'h11);
        drive(1, 0, 7, 0); step();
        chk("sh_pend_kept", rsp_rdata, 1);
        idle(); step();
`endif

        // back-to-back writes
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i, $urandom_range(0, 255));
            chk("b2b_ready", req_ready, 1);
            step();
            chk("b2b_valid", rsp_valid, 1);
        end
        idle(); step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 4) != 0, $urandom % 2,
                  ($urandom % 8 == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7),
                  $urandom_range(0, 255));
            rsp_ready     = ($urandom % 4) != 0;
            commit_strobe = ($urandom % 10) == 0;
            sts_in        = 16'($urandom & $urandom & $urandom);
            step();
        end
        idle(); rsp_ready = 1'b1; commit_strobe = 1'b0; sts_in = 16'h0000;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
